// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate/commit, CDB result capture, operand queries, mispredict flush.
// Define ROB_WB_BYPASS_EN to forward a same-cycle CDB writeback onto the query ports.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_branch,
    input  logic             alloc_pred_taken,
    input  logic [31:0]      alloc_pc,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_tag,
    input  logic [31:0]      wb_value,
    input  logic             wb_taken,
    input  logic [31:0]      wb_target,
    input  logic [IDX_W-1:0] query_tag1,
    input  logic [IDX_W-1:0] query_tag2,
    output logic             query_ready1,
    output logic             query_ready2,
    output logic [31:0]      query_value1,
    output logic [31:0]      query_value2,
    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [IDX_W-1:0] commit_tag,
    input  logic [IDX_W-1:0] commit_reorder_rd,
    output logic             commit_clear_busy,
    output logic             flush,
    output logic [31:0]      flush_pc
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_is_branch;
    logic [DEPTH-1:0] r_pred_taken;
    logic [DEPTH-1:0] r_taken;
    logic [4:0]       r_rd     [DEPTH];
    logic [31:0]      r_value  [DEPTH];
    logic [31:0]      r_target [DEPTH];
    logic [31:0]      r_pc     [DEPTH];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic             r_flush;
    logic [31:0]      r_flush_pc;

    logic w_commit;
    logic w_mispredict;
    logic w_retire;
    logic w_alloc;
    logic w_wb;

    // Full is judged on the registered count only, so a retiring slot is not reusable the same cycle.
    assign alloc_ready = (r_count != FULL_COUNT) && !r_flush;
    assign alloc_tag   = r_tail;

    assign w_commit     = rdy && r_busy[r_head] && r_ready[r_head] && !r_flush;
    assign w_mispredict = w_commit && r_is_branch[r_head] && (r_taken[r_head] != r_pred_taken[r_head]);
    assign w_retire     = w_commit && !w_mispredict;
    assign w_alloc      = rdy && alloc_valid && alloc_ready && !w_mispredict;
    assign w_wb         = rdy && wb_valid && r_busy[wb_tag] && !r_flush && !w_mispredict;

    assign commit_valid      = w_commit;
    assign commit_rd         = r_rd[r_head];
    assign commit_value      = r_value[r_head];
    assign commit_tag        = r_head;
    assign commit_clear_busy = w_commit && (commit_reorder_rd == r_head);

    assign flush    = r_flush;
    assign flush_pc = r_flush_pc;

    // NOTE: sequential state uses non-blocking assignments so every block samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else if (rdy) begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_busy     <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_flush_pc <= r_taken[r_head] ? r_target[r_head] : r_pc[r_head] + 32'd4;
            end else begin
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_alloc) begin
                    r_busy[r_tail] <= 1'b1;
                    r_tail         <= r_tail + 1'b1;
                end
                case ({w_alloc, w_retire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // NOTE: entry payload is not reset; busy gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_ready[r_tail]      <= 1'b0;
            r_rd[r_tail]         <= alloc_rd;
            r_is_branch[r_tail]  <= alloc_is_branch;
            r_pred_taken[r_tail] <= alloc_pred_taken;
            r_pc[r_tail]         <= alloc_pc;
        end
        if (w_wb) begin
            r_ready[wb_tag]  <= 1'b1;
            r_value[wb_tag]  <= wb_value;
            r_taken[wb_tag]  <= wb_taken;
            r_target[wb_tag] <= wb_target;
        end
    end

`ifdef ROB_WB_BYPASS_EN
    logic w_wb_live;
    assign w_wb_live = wb_valid && r_busy[wb_tag] && !r_flush;
`endif

    always_comb begin
        query_ready1 = r_busy[query_tag1] && r_ready[query_tag1];
        query_value1 = r_value[query_tag1];
        query_ready2 = r_busy[query_tag2] && r_ready[query_tag2];
        query_value2 = r_value[query_tag2];
`ifdef ROB_WB_BYPASS_EN
        if (w_wb_live && (wb_tag == query_tag1)) begin
            query_ready1 = 1'b1;
            query_value1 = wb_value;
        end
        if (w_wb_live && (wb_tag == query_tag2)) begin
            query_ready2 = 1'b1;
            query_value2 = wb_value;
        end
`else
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: table of single-cycle vectors plus multi-cycle sequences.
module tb_reorder_buffer;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_is_branch;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pc;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_value;
    logic        wb_taken;
    logic [31:0] wb_target;
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic [3:0]  commit_reorder_rd;
    logic        commit_clear_busy;
    logic        flush;
    logic [31:0] flush_pc;

    int total = 0;
    int bad   = 0;

    reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_value1(query_value1), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_tag(commit_tag), .commit_reorder_rd(commit_reorder_rd),
        .commit_clear_busy(commit_clear_busy),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic        wv;
        logic [3:0]  wt;
        logic [31:0] wval;
        logic [3:0]  qt;
        logic [3:0]  crr;
        logic        e_ar;
        logic [3:0]  e_tag;
        logic        e_cv;
        logic [4:0]  e_crd;
        logic [31:0] e_cval;
        logic [3:0]  e_ctag;
        logic        e_cb;
        logic        e_qr;
        logic [31:0] e_qv;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0; alloc_is_branch = 1'b0;
        alloc_pred_taken = 1'b0; alloc_pc = '0; wb_valid = 1'b0; wb_tag = '0;
        wb_value = '0; wb_taken = 1'b0; wb_target = '0; query_tag1 = '0;
        query_tag2 = '0; commit_reorder_rd = '0;
    endtask

    // Inputs change just after a falling edge; outputs are checked #1 later, well before the rising edge.
    task automatic adv();
        @(negedge clk);
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic br, input logic pt, input logic [31:0] pc);
        alloc_valid = 1'b1; alloc_rd = rd; alloc_is_branch = br;
        alloc_pred_taken = pt; alloc_pc = pc;
    endtask

    task automatic wb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        wb_valid = 1'b1; wb_tag = t; wb_value = v; wb_taken = tk; wb_target = tg;
    endtask

    initial begin
        //          av ard  wv wt wval       qt crr  ar tag cv crd cval       ctag cb qr   qv
        vecs[0] = '{0, 0,   0, 0, 0,         0, 0,   1, 0,  0, 0,  0,         0,   0, 0,   0};
        vecs[1] = '{1, 5,   0, 0, 0,         0, 0,   1, 0,  0, 0,  0,         0,   0, 0,   0};
        vecs[2] = '{1, 6,   0, 0, 0,         0, 0,   1, 1,  0, 0,  0,         0,   0, 0,   0};
        vecs[3] = '{1, 7,   0, 0, 0,         0, 0,   1, 2,  0, 0,  0,         0,   0, 0,   0};
        vecs[4] = '{0, 0,   1, 1, 32'h11,    1, 0,   1, 3,  0, 0,  0,         0,   0, BYP, 32'h11};
        vecs[5] = '{0, 0,   1, 0, 32'h22,    1, 0,   1, 3,  0, 0,  0,         0,   0, 1,   32'h11};
        vecs[6] = '{0, 0,   0, 0, 0,         0, 0,   1, 3,  1, 5,  32'h22,    0,   1, 1,   32'h22};
        vecs[7] = '{0, 0,   0, 0, 0,         0, 3,   1, 3,  1, 6,  32'h11,    1,   0, 0,   0};
        vecs[8] = '{0, 0,   0, 0, 0,         2, 0,   1, 3,  0, 0,  0,         0,   0, 0,   0};

        rst = 1'b1;
        do_reset();
        check("reset flush", {31'd0, flush}, 0);
        check("reset flush_pc", flush_pc, 0);

        // In-order commit of out-of-order writebacks
        for (int i = 0; i < 9; i++) begin
            idle();
            alloc_valid = vecs[i].av; alloc_rd = vecs[i].ard;
            wb_valid = vecs[i].wv; wb_tag = vecs[i].wt; wb_value = vecs[i].wval;
            query_tag1 = vecs[i].qt; commit_reorder_rd = vecs[i].crr;
            #1;
            check($sformatf("v%0d alloc_ready", i), {31'd0, alloc_ready}, {31'd0, vecs[i].e_ar});
            check($sformatf("v%0d alloc_tag", i), {28'd0, alloc_tag}, {28'd0, vecs[i].e_tag});
            check($sformatf("v%0d commit_valid", i), {31'd0, commit_valid}, {31'd0, vecs[i].e_cv});
            check($sformatf("v%0d clear_busy", i), {31'd0, commit_clear_busy}, {31'd0, vecs[i].e_cb});
            check($sformatf("v%0d query_ready1", i), {31'd0, query_ready1}, {31'd0, vecs[i].e_qr});
            if (vecs[i].e_cv) begin
                check($sformatf("v%0d commit_rd", i), {27'd0, commit_rd}, {27'd0, vecs[i].e_crd});
                check($sformatf("v%0d commit_value", i), commit_value, vecs[i].e_cval);
                check($sformatf("v%0d commit_tag", i), {28'd0, commit_tag}, {28'd0, vecs[i].e_ctag});
            end
            if (vecs[i].e_qr)
                check($sformatf("v%0d query_value1", i), query_value1, vecs[i].e_qv);
            adv();
        end

        // Full buffer: no 17th allocation, no same-cycle recycling
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(5'(i), 1'b0, 1'b0, 32'(i * 4));
            #1;
            check($sformatf("fill%0d alloc_ready", i), {31'd0, alloc_ready}, 1);
            check($sformatf("fill%0d alloc_tag", i), {28'd0, alloc_tag}, 32'(i));
            adv();
        end
        alloc(5'd20, 1'b0, 1'b0, 32'h0);
        #1;
        check("full alloc_ready", {31'd0, alloc_ready}, 0);
        adv();
        wb(4'd0, 32'h77, 1'b0, 32'h0);
        #1;
        check("full tail held", {28'd0, alloc_tag}, 0);
        check("full alloc_ready2", {31'd0, alloc_ready}, 0);
        adv();
        #1;
        check("full commit_valid", {31'd0, commit_valid}, 1);
        check("full commit_value", commit_value, 32'h77);
        check("full no recycle", {31'd0, alloc_ready}, 0);
        adv();
        #1;
        check("after commit alloc_ready", {31'd0, alloc_ready}, 1);
        check("after commit commit_rd", {27'd0, commit_rd}, 1);

        // Taken mispredict with two younger entries; same-cycle alloc/writeback discarded
        do_reset();
        alloc(5'd0, 1'b1, 1'b0, 32'h100);
        adv();
        alloc(5'd1, 1'b0, 1'b0, 32'h104);
        adv();
        alloc(5'd2, 1'b0, 1'b0, 32'h108);
        adv();
        wb(4'd0, 32'h0, 1'b1, 32'h200);
        #1;
        check("br commit early", {31'd0, commit_valid}, 0);
        adv();
        alloc(5'd3, 1'b0, 1'b0, 32'h10c);
        wb(4'd1, 32'h55, 1'b0, 32'h0);
        #1;
        check("br commit_valid", {31'd0, commit_valid}, 1);
        check("br pre flush", {31'd0, flush}, 0);
        adv();
        alloc(5'd4, 1'b0, 1'b0, 32'h110);
        query_tag1 = 4'd1;
        #1;
        check("br flush", {31'd0, flush}, 1);
        check("br flush_pc", flush_pc, 32'h200);
        check("br flush alloc_ready", {31'd0, alloc_ready}, 0);
        check("br flush commit", {31'd0, commit_valid}, 0);
        check("br flush tag", {28'd0, alloc_tag}, 0);
        check("br discarded wb", {31'd0, query_ready1}, 0);
        adv();
        #1;
        check("br flush pulse end", {31'd0, flush}, 0);
        check("br post alloc_ready", {31'd0, alloc_ready}, 1);
        check("br post alloc_tag", {28'd0, alloc_tag}, 0);

        // Correct prediction: no flush; then not-taken mispredict redirects to pc+4
        alloc(5'd0, 1'b1, 1'b1, 32'h300);
        adv();
        wb(4'd0, 32'h0, 1'b1, 32'h400);
        adv();
        #1;
        check("ok br commit", {31'd0, commit_valid}, 1);
        adv();
        #1;
        check("ok br no flush", {31'd0, flush}, 0);
        alloc(5'd0, 1'b1, 1'b1, 32'h500);
        adv();
        wb(4'd1, 32'h0, 1'b0, 32'h600);
        adv();
        #1;
        check("nt br commit", {31'd0, commit_valid}, 1);
        adv();
        #1;
        check("nt flush", {31'd0, flush}, 1);
        check("nt flush_pc", flush_pc, 32'h504);
        adv();

        // Writeback-to-query timing
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(5'(i + 1), 1'b0, 1'b0, 32'h0);
            adv();
        end
        wb(4'd2, 32'hAB, 1'b0, 32'h0);
        query_tag1 = 4'd2;
        query_tag2 = 4'd1;
        #1;
        check("byp same cycle ready1", {31'd0, query_ready1}, {31'd0, BYP});
        if (BYP) check("byp same cycle value1", query_value1, 32'hAB);
        check("byp other tag ready2", {31'd0, query_ready2}, 0);
        adv();
        query_tag1 = 4'd1;
        query_tag2 = 4'd2;
        #1;
        check("wb next ready2", {31'd0, query_ready2}, 1);
        check("wb next value2", query_value2, 32'hAB);
        check("wb not ready1", {31'd0, query_ready1}, 0);
        adv();

        // rdy low freezes a ready head and the tail
        do_reset();
        alloc(5'd9, 1'b0, 1'b0, 32'h0);
        adv();
        wb(4'd0, 32'h99, 1'b0, 32'h0);
        adv();
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            alloc(5'd10, 1'b0, 1'b0, 32'h0);
            #1;
            check($sformatf("stall%0d commit_valid", i), {31'd0, commit_valid}, 0);
            check($sformatf("stall%0d alloc_tag", i), {28'd0, alloc_tag}, 1);
            adv();
        end
        #1;
        check("resume commit_valid", {31'd0, commit_valid}, 1);
        check("resume commit_value", commit_value, 32'h99);
        check("resume commit_rd", {27'd0, commit_rd}, 9);
        adv();
        #1;
        check("resume done", {31'd0, commit_valid}, 0);
        check("resume alloc_tag", {28'd0, alloc_tag}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
